// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shifter sequencing controller: shifter op codes,
// command op encodings, FSM state type and the per-cycle shift limit.
package shift_seq_ctrl_pkg;

  // Shifter op codes (sh_op)
  localparam logic [2:0] SH_NOP  = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_LSL  = 3'b010;
  localparam logic [2:0] SH_LSR  = 3'b011;
  localparam logic [2:0] SH_ASR  = 3'b100;

  // Command op encodings (req_op)
  localparam logic [1:0] REQ_LOAD = 2'b00;
  localparam logic [1:0] REQ_LSL  = 2'b01;
  localparam logic [1:0] REQ_LSR  = 2'b10;
  localparam logic [1:0] REQ_ASR  = 2'b11;

  // Largest shift the shifter performs in one cycle (2-bit shamt)
  localparam int MAX_STEP = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Command op to shifter op; LOAD-only never reaches SHIFT, so it maps to NOP.
  function automatic logic [2:0] req_to_sh_op(input logic [1:0] op);
    logic [2:0] sh;
    sh = SH_NOP;
    case (op)
      REQ_LSL: sh = SH_LSL;
      REQ_LSR: sh = SH_LSR;
      REQ_ASR: sh = SH_ASR;
      default: sh = SH_NOP;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shamt_step.sv
// Splits the remaining shift amount into the next per-cycle step (at most
// MAX_STEP) and flags when this step finishes the command.
module shamt_step
  import shift_seq_ctrl_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic [AMT_W-1:0] rem,
  output logic [1:0]       step,
  output logic             last
);

  // Clamp the remaining amount to one shifter cycle's worth
  always_comb begin
    last = (rem <= AMT_W'(MAX_STEP));
    step = last ? rem[1:0] : 2'(MAX_STEP);
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the 8-bit shifter: accepts a command, loads the
// operand, issues as many <=3-position shifts as needed and returns the result.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; shifter held with NOP
// LOAD  | shifter loads the latched operand
// SHIFT | one shift of min(rem,3) positions per cycle, fed back from sh_q
// DONE  | done pulse; sh_q holds the final value and is captured to result
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [7:0]       req_data,
  input  logic [7:0]       sh_q,
  output logic [2:0]       sh_op,
  output logic [1:0]       sh_shamt,
  output logic [7:0]       sh_d_in,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       result_q, result_d;

  logic [1:0]       step;
  logic             last;

  shamt_step #(.AMT_W(AMT_W)) u_shamt_step (
    .rem  (rem_q),
    .step (step),
    .last (last)
  );

  // State and command registers; reset returns to IDLE from anywhere
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // Next-state, command latch and shifter drive
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    data_d   = data_q;
    result_d = result_q;
    sh_op    = SH_NOP;
    sh_shamt = 2'd0;
    sh_d_in  = sh_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          rem_d   = req_amt;
          data_d  = req_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sh_op   = SH_LOAD;
        sh_d_in = data_q;
        if (rem_q == '0 || op_q == REQ_LOAD) state_d = ST_DONE;
        else                                 state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The shifter shifts d_in, so the current register value is fed back
        sh_op    = req_to_sh_op(op_q);
        sh_shamt = step;
        rem_d    = rem_q - AMT_W'(step);
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = sh_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    result    = result_q;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shifter alongside it.
// Expected results, latencies and per-cycle shifter drive are queued when a
// command is issued and consumed as the controller runs.
module tb_shift_seq_ctrl;

  localparam logic [2:0] T_NOP = 3'b000, T_LOAD = 3'b001, T_LSL = 3'b010,
                         T_LSR = 3'b011, T_ASR = 3'b100;
  localparam logic [1:0] C_LOAD = 2'b00, C_LSL = 2'b01, C_LSR = 2'b10, C_ASR = 2'b11;

  typedef struct {
    logic [2:0] op;
    logic [1:0] shamt;
    logic       is_shift;
    logic [7:0] din;
  } trace_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [2:0] req_amt = '0;
  logic [7:0] req_data = '0;
  logic [7:0] sh_q;
  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  logic [7:0] sh_d_in;
  logic       busy, done;
  logic [7:0] result;

  int errors = 0;
  int checks = 0;

  int         exp_lat_q[$];
  logic [7:0] exp_res_q[$];
  trace_t     exp_tr_q[$];

  shift_seq_ctrl #(.AMT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .req_data  (req_data),
    .sh_q      (sh_q),
    .sh_op     (sh_op),
    .sh_shamt  (sh_shamt),
    .sh_d_in   (sh_d_in),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit shifter register driven by the controller
  logic [7:0] sh_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh_reg <= 8'h00;
    else begin
      case (sh_op)
        T_LOAD:  sh_reg <= sh_d_in;
        T_LSL:   sh_reg <= sh_d_in << sh_shamt;
        T_LSR:   sh_reg <= sh_d_in >> sh_shamt;
        T_ASR:   sh_reg <= 8'($signed(sh_d_in) >>> sh_shamt);
        default: sh_reg <= sh_reg;
      endcase
    end
  end
  assign sh_q = sh_reg;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result, latency and shifter drive for one command
  task automatic push_exp(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data);
    logic [7:0] res;
    logic [2:0] sop;
    int rem, step, lat;
    trace_t t;
    case (op)
      C_LSL:   begin res = data << amt;                 sop = T_LSL; end
      C_LSR:   begin res = data >> amt;                 sop = T_LSR; end
      C_ASR:   begin res = 8'($signed(data) >>> amt);   sop = T_ASR; end
      default: begin res = data;                        sop = T_NOP; end
    endcase
    lat = (op == C_LOAD || amt == 0) ? 2 : (int'(amt) + 2) / 3 + 2;
    exp_lat_q.push_back(lat);
    exp_res_q.push_back(res);
    t.op = T_LOAD; t.shamt = 2'd0; t.is_shift = 1'b0; t.din = data;
    exp_tr_q.push_back(t);
    rem = (op == C_LOAD) ? 0 : int'(amt);
    while (rem > 0) begin
      step = (rem > 3) ? 3 : rem;
      t.op = sop; t.shamt = 2'(step); t.is_shift = 1'b1; t.din = 8'h00;
      exp_tr_q.push_back(t);
      rem -= step;
    end
  endtask

  // Called at a negedge; returns 1ns after the accepting edge with valid still high
  task automatic issue(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_amt   = amt;
    req_data  = data;
    #1;
    chk("ready_at_accept", req_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Follows one command to completion; returns at the negedge after done
  task automatic complete(input string name);
    int lat, k, used;
    logic [7:0] res;
    logic seen;
    trace_t t;
    lat  = exp_lat_q.pop_front();
    res  = exp_res_q.pop_front();
    used = 0;
    seen = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      chk({name, "_busy"}, busy, 1);
      chk({name, "_ready_low"}, req_ready, 0);
      if (used < lat - 1) begin
        t = exp_tr_q.pop_front();
        used++;
        chk({name, "_sh_op"}, sh_op, t.op);
        if (t.is_shift) begin
          chk({name, "_sh_shamt"}, sh_shamt, t.shamt);
          chk({name, "_d_in_feedback"}, sh_d_in, sh_q);
        end else begin
          chk({name, "_d_in_load"}, sh_d_in, t.din);
        end
      end
    end
    while (used < lat - 1) begin
      void'(exp_tr_q.pop_front());
      used++;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_latency"}, k, lat);
      chk({name, "_done_busy"}, busy, 1);
      chk({name, "_done_sh_op"}, sh_op, T_NOP);
      chk({name, "_value_at_done"}, sh_q, res);
      @(negedge clk);
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_result"}, result, res);
      chk({name, "_ready_after"}, req_ready, 1);
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [2:0] amt,
                     input logic [7:0] data);
    push_exp(op, amt, data);
    issue(op, amt, data);
    req_valid = 1'b0;
    req_data  = ~data;
    req_amt   = amt ^ 3'b101;
    complete(name);
  endtask

  initial begin
    logic [1:0] rop;
    logic [2:0] ramt;
    logic [7:0] rdata;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sh_op", sh_op, T_NOP);
    chk("rst_sh_shamt", sh_shamt, 0);
    chk("rst_sh_d_in", sh_d_in, sh_q);
    chk("rst_result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run("lsl5",    C_LSL,  3'd5, 8'h81);
    run("asr7",    C_ASR,  3'd7, 8'h80);
    run("lsr7",    C_LSR,  3'd7, 8'h80);
    run("lsr0",    C_LSR,  3'd0, 8'hA5);
    run("load6",   C_LOAD, 3'd6, 8'h3C);
    run("asr3",    C_ASR,  3'd3, 8'h90);
    run("lsl1",    C_LSL,  3'd1, 8'h01);
    run("asr4pos", C_ASR,  3'd4, 8'h7F);

    // Back-to-back: valid held high, second command presented while busy
    push_exp(C_LSL, 3'd2, 8'h0F);
    push_exp(C_ASR, 3'd4, 8'h40);
    issue(C_LSL, 3'd2, 8'h0F);
    req_op = C_ASR; req_amt = 3'd4; req_data = 8'h40;
    complete("b2b_a");
    issue(C_ASR, 3'd4, 8'h40);
    req_op = C_LSR; req_amt = 3'd7; req_data = 8'hEE;
    #1;
    chk("b2b_ready_low_after_accept", req_ready, 0);
    req_valid = 1'b0;
    complete("b2b_b");

    // Reset during SHIFT of an amount-7 command
    issue(C_ASR, 3'd7, 8'h80);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_shift", sh_op, T_ASR);
    chk("mid_result_before", result, 8'h04);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sh_op", sh_op, T_NOP);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_shamt", sh_shamt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run("after_rst", C_LSL, 3'd1, 8'h55);

    for (int i = 0; i < 8; i++) begin
      rop   = 2'($urandom_range(0, 3));
      ramt  = 3'($urandom_range(0, 7));
      rdata = 8'($urandom);
      run("rand", rop, ramt, rdata);
    end

    chk("queues_drained", exp_tr_q.size() + exp_lat_q.size() + exp_res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
